// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the serial digit adder.
package serial_digit_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit slices needed to cover a full operand.
  function automatic int NUM_DIGITS(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter width, never narrower than one bit.
  function automatic int CNT_WIDTH(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// Combinational ripple-carry slice that adds one DIGIT-bit chunk per cycle.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  // Classic full-adder cells chained bit by bit; c[i] is the carry into bit i.
  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit slice per RUN cycle, valid/ready on both sides.
module serial_digit_adder
  import serial_digit_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int ND = NUM_DIGITS(WIDTH, DIGIT);
  localparam int CW = CNT_WIDTH(ND);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_digit_adder: WIDTH must be a nonzero multiple of DIGIT");
  end

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;

  logic [DIGIT-1:0] dig_s;
  logic             dig_co;
  logic             dig_cmsb;
  logic [WIDTH-1:0] dig_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last_digit;

  // Operands shift right each cycle, so the active digit always sits in the low bits.
  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .ci    (carry_q),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // New digits enter the accumulator at the top; after ND shifts it holds the whole result.
  always_comb begin
    dig_ext    = WIDTH'(dig_s);
    acc_next   = (acc_q >> DIGIT) | (dig_ext << (WIDTH - DIGIT));
    last_digit = (cnt_q == CW'(ND - 1));
  end

  // Control FSM plus all datapath registers; outputs are registered and only updated on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : cin;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= acc_next;
          carry_q <= dig_co;
          cnt_q   <= cnt_q + CW'(1);
          if (last_digit) begin
            sum       <= acc_next;
            cout      <= dig_co;
            ovf       <= dig_cmsb ^ dig_co;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder with DIGIT=4, DIGIT=1 and DIGIT=16 instances.
module tb_serial_digit_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [15:0] sum_w  [3];
  logic        cout_w [3];
  logic        ovf_w  [3];

  int checks = 0;
  int errors = 0;

  logic [15:0] rs;
  logic        rc;
  logic        ro;
  int          rlat;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sum_w[0]), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sum_w[1]), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sum_w[2]), .cout(cout_w[2]), .ovf(ovf_w[2])
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one operation to instance inst, scrambles the inputs during RUN, waits for out_valid.
  task automatic applyStimulus(input string tag, input int inst,
                               input logic [15:0] a_i, input logic [15:0] b_i,
                               input logic sub_i, input logic cin_i,
                               output logic [15:0] s, output logic c, output logic o,
                               output int lat);
    @(negedge clk);
    checkOutput({tag, " in_ready before"}, {31'd0, ir[inst]}, 32'd1);
    a = a_i; b = b_i; sub = sub_i; cin = cin_i;
    iv[inst] = 1'b1;
    @(posedge clk); #1;
    iv[inst] = 1'b0;
    a = ~a_i; b = ~b_i; sub = ~sub_i; cin = ~cin_i;
    lat = 0;
    while (!ov[inst] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sum_w[inst];
    c = cout_w[inst];
    o = ovf_w[inst];
  endtask

  // Completes the result handshake and confirms the return to IDLE.
  task automatic finishResult(input string tag, input int inst);
    @(negedge clk);
    ordy[inst] = 1'b1;
    @(posedge clk); #1;
    ordy[inst] = 1'b0;
    checkOutput({tag, " out_valid after hs"}, {31'd0, ov[inst]}, 32'd0);
    checkOutput({tag, " in_ready after hs"}, {31'd0, ir[inst]}, 32'd1);
  endtask

  task automatic runOp(input string tag, input int inst,
                       input logic [15:0] a_i, input logic [15:0] b_i,
                       input logic sub_i, input logic cin_i,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int elat);
    applyStimulus(tag, inst, a_i, b_i, sub_i, cin_i, rs, rc, ro, rlat);
    checkOutput({tag, " latency"}, rlat, elat);
    checkOutput({tag, " sum"}, {16'd0, rs}, {16'd0, es});
    checkOutput({tag, " cout"}, {31'd0, rc}, {31'd0, ec});
    checkOutput({tag, " ovf"}, {31'd0, ro}, {31'd0, eo});
    finishResult(tag, inst);
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {31'd0, ir[0]}, 32'd1);
    checkOutput("reset out_valid", {31'd0, ov[0]}, 32'd0);
    checkOutput("reset sum", {16'd0, sum_w[0]}, 32'd0);
    checkOutput("reset cout", {31'd0, cout_w[0]}, 32'd0);
    checkOutput("reset ovf", {31'd0, ovf_w[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp("add1234", 0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4);
    runOp("addFFFF1", 0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4);
    runOp("addcin", 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 4);
    runOp("add7FFF1", 0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4);
    runOp("add8000", 0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4);
    runOp("sub5m7", 0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4);
    runOp("sub8000m1", 0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 4);

    applyStimulus("hold", 0, 16'h00FF, 16'h0F01, 1'b0, 1'b0, rs, rc, ro, rlat);
    checkOutput("hold latency", rlat, 4);
    checkOutput("hold sum", {16'd0, rs}, 32'h1000);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; iv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d sum", k), {16'd0, sum_w[0]}, 32'h1000);
      checkOutput($sformatf("hold%0d cout", k), {31'd0, cout_w[0]}, 32'd0);
      checkOutput($sformatf("hold%0d ovf", k), {31'd0, ovf_w[0]}, 32'd0);
      checkOutput($sformatf("hold%0d out_valid", k), {31'd0, ov[0]}, 32'd1);
      checkOutput($sformatf("hold%0d in_ready", k), {31'd0, ir[0]}, 32'd0);
    end
    iv[0] = 1'b0;
    finishResult("hold", 0);
    runOp("afterhold", 0, 16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3334, 1'b0, 1'b0, 4);

    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; cin = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", {31'd0, ov[0]}, 32'd0);
    checkOutput("abort in_ready", {31'd0, ir[0]}, 32'd1);
    checkOutput("abort sum", {16'd0, sum_w[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("postreset", 0, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 4);

    runOp("digit1", 1, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 16);
    runOp("digit16", 2, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
    runOp("digit16sub", 2, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
